// File: rtl/gb_host_bridge_if.sv
// Signal bundle between a host command link, the host bridge and the ghostbus.
// The bridge uses the master modport (it masters the ghostbus and serves the
// command/response streams); the host link plus fabric side uses slave.
interface gb_host_bridge_if #(
  parameter int GB_AW = 24,
  parameter int GB_DW = 32
);
  // Command stream from the host link
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [GB_AW-1:0] cmd_addr;
  logic [GB_DW-1:0] cmd_wdata;
  // Read response stream back to the host link
  logic             rsp_valid;
  logic             rsp_ready;
  logic [GB_DW-1:0] rsp_data;
  // Ghostbus side
  logic [GB_AW-1:0] gb_addr;
  logic [GB_DW-1:0] gb_wdata;
  logic             gb_wen;
  logic             gb_rstb;
  logic [GB_DW-1:0] gb_rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, gb_rdata,
    output cmd_ready, rsp_valid, rsp_data, gb_addr, gb_wdata, gb_wen, gb_rstb
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, gb_rdata,
    input  cmd_ready, rsp_valid, rsp_data, gb_addr, gb_wdata, gb_wen, gb_rstb
  );
endinterface

// File: rtl/gb_host_bridge.sv
// Host-side bus master for the ghostbus fabric. Turns a command stream into
// single-cycle write/read strobes and returns read data, captured a fixed
// RD_DELAY cycles after the read strobe, on a response stream.
//
// Handshake rule for both streams: a transfer happens at a rising edge of
// gb_clk where valid and ready are both high. A producer keeps its payload
// stable while valid is high and not yet taken; ready never depends on valid.
// cmd_ready is high only in IDLE and WR, so a single read is outstanding at
// a time and no command is taken from the read strobe until the response
// has been consumed.
module gb_host_bridge #(
  parameter int GB_AW    = 24,
  parameter int GB_DW    = 32,
  parameter int RD_DELAY = 1    // 1..15 cycles from strobe to rdata-valid
) (
  input  logic              gb_clk,
  input  logic              gb_rst_n,
  gb_host_bridge_if.master  bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(RD_DELAY - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt_q, cnt_nxt;
  logic [GB_AW-1:0] addr_q, addr_nxt;
  logic [GB_DW-1:0] wdata_q, wdata_nxt;
  logic             wen_q, wen_nxt;
  logic             rstb_q, rstb_nxt;
  logic             rsp_valid_q, rsp_valid_nxt;
  logic [GB_DW-1:0] rsp_data_q, rsp_data_nxt;
  logic             cmd_ready_w;
  logic             accept;

  // Ready is a pure state decode, forced low while reset is held
  assign cmd_ready_w = gb_rst_n && ((state == S_IDLE) || (state == S_WR));
  assign accept      = bus.cmd_valid && cmd_ready_w;

  // Next-state and next-output decode
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    wen_nxt       = 1'b0;
    rstb_nxt      = 1'b0;
    rsp_valid_nxt = rsp_valid_q;
    rsp_data_nxt  = rsp_data_q;
    case (state)
      S_IDLE, S_WR: begin
        if (accept) begin
          addr_nxt = bus.cmd_addr;
          if (bus.cmd_we) begin
            wdata_nxt = bus.cmd_wdata;
            wen_nxt   = 1'b1;
            state_nxt = S_WR;
          end else begin
            rstb_nxt  = 1'b1;
            state_nxt = S_RD;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_nxt  = bus.gb_rdata;
          rsp_valid_nxt = 1'b1;
          state_nxt     = S_RESP;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any strobe or pending response
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state       <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      rstb_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      cnt_q       <= cnt_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      wen_q       <= wen_nxt;
      rstb_q      <= rstb_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_data_q  <= rsp_data_nxt;
    end
  end

  assign bus.cmd_ready = cmd_ready_w;
  assign bus.gb_addr   = addr_q;
  assign bus.gb_wdata  = wdata_q;
  assign bus.gb_wen    = wen_q;
  assign bus.gb_rstb   = rstb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_gb_host_bridge.sv
// Bench for gb_host_bridge: one instance with RD_DELAY=1 (directed + random
// traffic against a memory reference model) and one with RD_DELAY=4.
module tb_gb_host_bridge;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int D1 = 1;
  localparam int D4 = 4;

  // ---------------- clock / reset ----------------
  logic gb_clk = 1'b0;
  logic gb_rst_n;
  always #5 gb_clk = ~gb_clk;

  int cyc = 0;
  always @(posedge gb_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  logic [2:0] state_dbg1, state_dbg4;
  gb_host_bridge_if #(.GB_AW(AW), .GB_DW(DW)) bus1 ();
  gb_host_bridge_if #(.GB_AW(AW), .GB_DW(DW)) bus4 ();

  gb_host_bridge #(.GB_AW(AW), .GB_DW(DW), .RD_DELAY(D1)) u_dut1 (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .bus(bus1), .state_dbg(state_dbg1));
  gb_host_bridge #(.GB_AW(AW), .GB_DW(DW), .RD_DELAY(D4)) u_dut4 (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .bus(bus4), .state_dbg(state_dbg4));

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  bit rnd_mode = 1'b0;
  int exp_rise = 0;
  logic [31:0] exp_q[$];                 // expected read responses, in order
  logic [55:0] wr_q[$];                  // expected {addr, data} write strobes
  logic [23:0] rd_q[$];                  // expected read strobe addresses
  logic [31:0] exp_mem [logic [23:0]];   // reference memory (from commands)
  logic [31:0] mem1    [logic [23:0]];   // fabric memory (from bus strobes)
  int pend1 = 0;
  int pend4 = 0;
  logic [23:0] pa1;
  logic [31:0] rd4_val = 32'h0;
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  logic [31:0] prev_d = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [23:0] a);
    return {8'hC3, a};
  endfunction

  function automatic logic [31:0] ref_read(input logic [23:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  // ---------------- ghostbus fabric models ----------------
  // Fabric 1: memory; read data valid only in the RD_DELAY-th cycle after strobe
  always @(negedge gb_clk) begin
    if (bus1.gb_wen) mem1[bus1.gb_addr] = bus1.gb_wdata;
    if (bus1.gb_rstb) begin
      pend1 = D1;
      pa1 = bus1.gb_addr;
      bus1.gb_rdata = '1;
    end else if (pend1 > 0) begin
      pend1--;
      bus1.gb_rdata = (pend1 == 0) ? (mem1.exists(pa1) ? mem1[pa1] : init_val(pa1)) : '1;
    end else begin
      bus1.gb_rdata = '1;
    end
  end

  // Fabric 4: all-ones except rd4_val in the 4th cycle after the strobe
  always @(negedge gb_clk) begin
    if (bus4.gb_rstb) begin
      pend4 = D4;
      bus4.gb_rdata = '1;
    end else if (pend4 > 0) begin
      pend4--;
      bus4.gb_rdata = (pend4 == 0) ? rd4_val : '1;
    end else begin
      bus4.gb_rdata = '1;
    end
  end

  // ---------------- bus monitor for instance 1 ----------------
  always @(negedge gb_clk) begin
    #1;
    if (!gb_rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      check("strobe_excl", 64'(bus1.gb_wen && bus1.gb_rstb), 64'd0);
      if (bus1.gb_wen) begin
        check("wen_pending", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) check("wen_addr_data", 64'({bus1.gb_addr, bus1.gb_wdata}), 64'(wr_q.pop_front()));
      end
      if (bus1.gb_rstb) begin
        check("rstb_pending", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) check("rstb_addr", 64'(bus1.gb_addr), 64'(rd_q.pop_front()));
      end
      if (bus1.rsp_valid && !prev_v) check("rsp_latency", 64'(cyc), 64'(exp_rise));
      if (prev_v && !prev_hs) begin
        check("rsp_hold_valid", 64'(bus1.rsp_valid), 64'd1);
        check("rsp_hold_data", 64'(bus1.rsp_data), 64'(prev_d));
      end
      if (bus1.rsp_valid && bus1.rsp_ready) begin
        check("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("rsp_data", 64'(bus1.rsp_data), 64'(exp_q.pop_front()));
      end
      prev_v  = bus1.rsp_valid;
      prev_hs = bus1.rsp_valid && bus1.rsp_ready;
      prev_d  = bus1.rsp_data;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after acceptance with
  // cmd_valid still high so the caller can chain another command.
  task automatic send(input logic we, input logic [23:0] addr, input logic [31:0] wd);
    int n = 0;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_we    = we;
    bus1.cmd_addr  = addr;
    bus1.cmd_wdata = wd;
    while (!bus1.cmd_ready && n <= 100) begin
      if (rnd_mode) begin
        bus1.cmd_valid = 1'($urandom_range(0, 1));
        bus1.cmd_we    = 1'($urandom_range(0, 1));
        bus1.cmd_addr  = 24'($urandom);
        bus1.cmd_wdata = $urandom;
        bus1.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge gb_clk);
      n++;
    end
    check("cmd_accept_bound", 64'(n <= 100), 64'd1);
    bus1.cmd_valid = 1'b1;
    bus1.cmd_we    = we;
    bus1.cmd_addr  = addr;
    bus1.cmd_wdata = wd;
    if (we) begin
      exp_mem[addr] = wd;
      wr_q.push_back({addr, wd});
    end else begin
      rd_q.push_back(addr);
      exp_q.push_back(ref_read(addr));
      exp_rise = cyc + 1 + 1 + D1;
    end
    @(negedge gb_clk);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus1.rsp_valid) && n < 60) begin
      @(negedge gb_clk);
      n++;
    end
    check(tag, 64'(n < 60), 64'd1);
  endtask

  task automatic read4(input logic [23:0] a, input logic [31:0] v);
    int n = 0;
    rd4_val = v;
    bus4.cmd_valid = 1'b1;
    bus4.cmd_we    = 1'b0;
    bus4.cmd_addr  = a;
    bus4.cmd_wdata = $urandom;
    while (!bus4.cmd_ready && n < 20) begin
      @(negedge gb_clk);
      n++;
    end
    check("d4_accept", 64'(n < 20), 64'd1);
    @(negedge gb_clk);
    bus4.cmd_valid = 1'b0;
    check("d4_rstb", 64'(bus4.gb_rstb), 64'd1);
    check("d4_addr", 64'(bus4.gb_addr), 64'(a));
    check("d4_ready_low", 64'(bus4.cmd_ready), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge gb_clk);
      check("d4_valid_timing", 64'(bus4.rsp_valid), 64'(k >= 1 + D4));
      check("d4_rstb_single", 64'(bus4.gb_rstb), 64'd0);
    end
    check("d4_data", 64'(bus4.rsp_data), 64'(v));
    bus4.rsp_ready = 1'b1;
    @(negedge gb_clk);
    check("d4_release", 64'(bus4.rsp_valid), 64'd0);
    check("d4_idle_ready", 64'(bus4.cmd_ready), 64'd1);
    bus4.rsp_ready = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    gb_rst_n = 1'b0;
    bus1.cmd_valid = 1'b1;  // must be ignored while reset is held
    bus1.cmd_we = 1'b1;
    bus1.cmd_addr = 24'h0000AA;
    bus1.cmd_wdata = 32'h11111111;
    bus1.rsp_ready = 1'b1;
    bus4.cmd_valid = 1'b0;
    bus4.cmd_we = 1'b0;
    bus4.cmd_addr = '0;
    bus4.cmd_wdata = '0;
    bus4.rsp_ready = 1'b0;
    repeat (3) @(negedge gb_clk);

    // Reset values
    check("rst_cmd_ready", 64'(bus1.cmd_ready), 64'd0);
    check("rst_wen", 64'(bus1.gb_wen), 64'd0);
    check("rst_rstb", 64'(bus1.gb_rstb), 64'd0);
    check("rst_addr", 64'(bus1.gb_addr), 64'd0);
    check("rst_wdata", 64'(bus1.gb_wdata), 64'd0);
    check("rst_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus1.rsp_data), 64'd0);
    check("rst_state", 64'(state_dbg1), 64'd0);
    check("rst_cmd_ready4", 64'(bus4.cmd_ready), 64'd0);
    bus1.cmd_valid = 1'b0;
    gb_rst_n = 1'b1;
    @(negedge gb_clk);
    check("idle_ready", 64'(bus1.cmd_ready), 64'd1);
    check("idle_no_wen", 64'(bus1.gb_wen), 64'd0);

    // Single write
    send(1'b1, 24'h000010, 32'hDEADBEEF);
    check("wr1_wen", 64'(bus1.gb_wen), 64'd1);
    check("wr1_addr", 64'(bus1.gb_addr), 64'h10);
    check("wr1_wdata", 64'(bus1.gb_wdata), 64'hDEADBEEF);
    check("wr1_rstb", 64'(bus1.gb_rstb), 64'd0);
    bus1.cmd_valid = 1'b0;
    @(negedge gb_clk);
    check("wr1_wen_drop", 64'(bus1.gb_wen), 64'd0);
    check("wr1_no_rsp", 64'(bus1.rsp_valid), 64'd0);

    // Three back-to-back writes
    send(1'b1, 24'h000020, 32'h1);
    check("b2b1_ready", 64'(bus1.cmd_ready), 64'd1);
    check("b2b1_wen", 64'(bus1.gb_wen), 64'd1);
    send(1'b1, 24'h000024, 32'h2);
    check("b2b2_ready", 64'(bus1.cmd_ready), 64'd1);
    check("b2b2_wen", 64'(bus1.gb_wen), 64'd1);
    send(1'b1, 24'h000028, 32'h3);
    check("b2b3_ready", 64'(bus1.cmd_ready), 64'd1);
    check("b2b3_wen", 64'(bus1.gb_wen), 64'd1);
    bus1.cmd_valid = 1'b0;
    @(negedge gb_clk);
    check("b2b_wen_drop", 64'(bus1.gb_wen), 64'd0);

    // Read with RD_DELAY=1, consumer always ready
    send(1'b0, 24'h000010, 32'h0BAD0BAD);
    bus1.cmd_valid = 1'b0;
    check("rd_rstb", 64'(bus1.gb_rstb), 64'd1);
    check("rd_wen_low", 64'(bus1.gb_wen), 64'd0);
    check("rd_addr", 64'(bus1.gb_addr), 64'h10);
    check("rd_wdata_kept", 64'(bus1.gb_wdata), 64'h3);
    check("rd_ready_low0", 64'(bus1.cmd_ready), 64'd0);
    @(negedge gb_clk);
    check("rd_valid_early", 64'(bus1.rsp_valid), 64'd0);
    check("rd_ready_low1", 64'(bus1.cmd_ready), 64'd0);
    check("rd_rstb_single", 64'(bus1.gb_rstb), 64'd0);
    @(negedge gb_clk);
    check("rd_valid", 64'(bus1.rsp_valid), 64'd1);
    check("rd_data", 64'(bus1.rsp_data), 64'hDEADBEEF);
    check("rd_ready_low2", 64'(bus1.cmd_ready), 64'd0);
    @(negedge gb_clk);
    check("rd_valid_drop", 64'(bus1.rsp_valid), 64'd0);
    check("rd_back_idle", 64'(bus1.cmd_ready), 64'd1);
    check("rd_addr_hold", 64'(bus1.gb_addr), 64'h10);

    // Read with consumer back-pressure for 10 cycles
    bus1.rsp_ready = 1'b0;
    send(1'b0, 24'h000024, 32'h0);
    bus1.cmd_valid = 1'b0;
    n = 0;
    while (!bus1.rsp_valid && n < 20) begin
      @(negedge gb_clk);
      n++;
    end
    check("bp_rsp_seen", 64'(n < 20), 64'd1);
    bus1.cmd_valid = 1'b1;   // stray write that must not be taken
    bus1.cmd_we = 1'b1;
    bus1.cmd_addr = 24'h00003C;
    bus1.cmd_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 64'(bus1.rsp_valid), 64'd1);
      check("bp_data", 64'(bus1.rsp_data), 64'h2);
      check("bp_ready_low", 64'(bus1.cmd_ready), 64'd0);
      @(negedge gb_clk);
    end
    bus1.cmd_valid = 1'b0;
    bus1.rsp_ready = 1'b1;
    @(negedge gb_clk);
    check("bp_release", 64'(bus1.rsp_valid), 64'd0);
    check("bp_idle_ready", 64'(bus1.cmd_ready), 64'd1);
    check("bp_idle_state", 64'(state_dbg1), 64'd0);

    // RD_DELAY=4 instance
    read4(24'h000100, 32'h12345678);
    read4(24'($urandom), $urandom_range(0, 32'h7FFFFFFF));
    read4(24'($urandom), $urandom_range(0, 32'h7FFFFFFF));

    // Reset in the middle of a read
    send(1'b0, 24'h000028, 32'h0);
    bus1.cmd_valid = 1'b0;
    @(negedge gb_clk);
    gb_rst_n = 1'b0;
    #1;
    check("mid_rst_wen", 64'(bus1.gb_wen), 64'd0);
    check("mid_rst_rstb", 64'(bus1.gb_rstb), 64'd0);
    check("mid_rst_valid", 64'(bus1.rsp_valid), 64'd0);
    check("mid_rst_ready", 64'(bus1.cmd_ready), 64'd0);
    check("mid_rst_addr", 64'(bus1.gb_addr), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge gb_clk);
    gb_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge gb_clk);
      check("post_rst_no_rsp", 64'(bus1.rsp_valid), 64'd0);
    end
    send(1'b1, 24'h00002C, 32'hA5A55A5A);
    send(1'b0, 24'h00002C, 32'h0);
    bus1.cmd_valid = 1'b0;
    wait_drain("post_rst_drain");

    // Randomized traffic against the reference memory
    rnd_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(1'($urandom_range(0, 1)), 24'($urandom_range(0, 7) * 4 + 24'h40), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        bus1.cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          bus1.rsp_ready = ($urandom_range(0, 3) != 0);
          @(negedge gb_clk);
        end
      end
    end
    rnd_mode = 1'b0;
    bus1.cmd_valid = 1'b0;
    bus1.rsp_ready = 1'b1;
    wait_drain("final_drain");
    repeat (3) @(negedge gb_clk);
    check("final_exp_q", 64'(exp_q.size()), 64'd0);
    check("final_wr_q", 64'(wr_q.size()), 64'd0);
    check("final_rd_q", 64'(rd_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
